// File: rtl/m_clk_div_ctrl.sv
// Programmable clock-divider controller: per-period enable pulse plus a registered
// divided clock. The divide ratio changes via a req/ack handshake, only at period boundaries.
module m_clk_div_ctrl #(
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned RESET_DIV = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_req,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ack,
  output logic             clk_en,
  output logic             clk_div,
  output logic [DIV_W-1:0] div_cur,
  output logic             running
);

  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);

  typedef enum logic [1:0] {IDLE, RUN, PEND, ACKW} state_t;

  state_t           state, nxt_state;
  logic [DIV_W-1:0] cnt, nxt_cnt, nxt_div, pend_val, nxt_pend, take_val;
  logic             nxt_ack, at_end, take;

  always_comb begin
    at_end    = (div_cur != '0) && (cnt == div_cur - ONE);
    nxt_state = state;
    nxt_div   = div_cur;
    nxt_pend  = pend_val;
    nxt_ack   = 1'b0;
    nxt_cnt   = (div_cur == '0) ? cnt : (at_end ? '0 : cnt + ONE);
    take      = 1'b0;
    take_val  = div_val;
    case (state)
      IDLE: take = div_req;
      RUN: begin
        if (div_req) begin
          // A request arriving in the boundary cycle is applied right away.
          if (at_end) begin
            take = 1'b1;
          end else begin
            nxt_pend  = div_val;
            nxt_state = PEND;
          end
        end
      end
      PEND: begin
        if (at_end) begin
          take     = 1'b1;
          take_val = pend_val;
        end
      end
      ACKW: begin
        if (!div_req) nxt_state = (div_cur == '0) ? IDLE : RUN;
      end
      default: nxt_state = IDLE;
    endcase
    // A zero ratio also parks in ACKW so a still-high div_req is not re-accepted.
    if (take) begin
      nxt_div   = take_val;
      nxt_cnt   = '0;
      nxt_ack   = 1'b1;
      nxt_state = ACKW;
    end
  end

  // Output flops are loaded from next-state values so they line up with cnt/div_cur.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= (RST_DIV != '0) ? RUN : IDLE;
      cnt      <= '0;
      div_cur  <= RST_DIV;
      pend_val <= '0;
      div_ack  <= 1'b0;
      clk_en   <= (RST_DIV == ONE);
      clk_div  <= ('0 < (RST_DIV >> 1));
      running  <= (RST_DIV != '0);
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      div_cur  <= nxt_div;
      pend_val <= nxt_pend;
      div_ack  <= nxt_ack;
      clk_en   <= (nxt_div != '0) && (nxt_cnt == nxt_div - ONE);
      clk_div  <= (nxt_cnt < (nxt_div >> 1));
      running  <= (nxt_div != '0);
    end
  end

endmodule

// File: tb/tb_m_clk_div_ctrl.sv
// Self-checking bench for m_clk_div_ctrl: expected per-cycle outputs are queued
// from the period definition and compared against the DUT each cycle.
module tb_m_clk_div_ctrl;

  localparam int unsigned DIV_W = 8;
  typedef logic [DIV_W+3:0] obs_t;  // {ack, en, div, run, cur}

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b1;
  logic             div_req = 1'b0;
  logic [DIV_W-1:0] div_val = '0;
  logic             div_ack, clk_en, clk_div, running;
  logic [DIV_W-1:0] div_cur;

  logic             req3 = 1'b0;
  logic [DIV_W-1:0] val3 = '0;
  logic             ack3, en3, dv3, run3;
  logic [DIV_W-1:0] cur3;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  obs_t sb[$];
  obs_t sb3[$];

  always #5 clk = ~clk;

  m_clk_div_ctrl #(.DIV_W(DIV_W), .RESET_DIV(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .div_req(div_req), .div_val(div_val),
    .div_ack(div_ack), .clk_en(clk_en), .clk_div(clk_div),
    .div_cur(div_cur), .running(running)
  );

  m_clk_div_ctrl #(.DIV_W(DIV_W), .RESET_DIV(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .div_req(req3), .div_val(val3),
    .div_ack(ack3), .clk_en(en3), .clk_div(dv3),
    .div_cur(cur3), .running(run3)
  );

  function automatic obs_t mk(logic ack, int unsigned n, int unsigned c);
    mk = {ack, (n != 0) && (c == n - 1), c < n / 2, n != 0, DIV_W'(n)};
  endfunction

  // Ratio n in effect from the first pushed cycle, which carries the ack pulse.
  task automatic exp_period(int unsigned n, int unsigned cycles);
    for (int unsigned k = 0; k < cycles; k++)
      sb.push_back(mk(k == 0, n, (n == 0) ? 0 : k % n));
  endtask

  task automatic exp_idle(int unsigned cycles);
    for (int unsigned k = 0; k < cycles; k++) sb.push_back(mk(1'b0, 0, 0));
  endtask

  task automatic reset_dut();
    div_req = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    #1 rst_n = 1'b0;
    #1;
    sb.push_back(mk(1'b0, 0, 0));
    sb3.push_back(mk(1'b0, 3, 0));
    got  = {div_ack, clk_en, clk_div, running, div_cur};
    want = sb.pop_front();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_async: got %h want %h", got, want);
    end
    got  = {ack3, en3, dv3, run3, cur3};
    want = sb3.pop_front();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_async_div3: got %h want %h", got, want);
    end
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_idle(9);
    for (int unsigned k = 0; k < 9; k++) sb3.push_back(mk(1'b0, 3, k % 3));
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      got  = {div_ack, clk_en, clk_div, running, div_cur};
      want = (sb.size() != 0) ? sb.pop_front() : 'x;
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got %h want %h", i, got, want);
      end
      got  = {ack3, en3, dv3, run3, cur3};
      want = (sb3.size() != 0) ? sb3.pop_front() : 'x;
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_run_div3 cyc %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_idle_start();
    obs_t got, want;
    reset_dut();
    exp_idle(11);
    exp_period(4, 12);
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      got  = {div_ack, clk_en, clk_div, running, div_cur};
      want = (sb.size() != 0) ? sb.pop_front() : 'x;
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL idle_start cyc %0d: got %h want %h", i, got, want);
      end
      case (i)
        10: begin div_req = 1'b1; div_val = 8'd4; end
        11: div_req = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_change_ratio();
    obs_t got, want;
    reset_dut();
    exp_idle(1);
    exp_period(4, 4);
    exp_period(3, 8);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      got  = {div_ack, clk_en, clk_div, running, div_cur};
      want = (sb.size() != 0) ? sb.pop_front() : 'x;
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL change_ratio cyc %0d: got %h want %h", i, got, want);
      end
      case (i)
        0: begin div_req = 1'b1; div_val = 8'd4; end
        1: div_req = 1'b0;
        2: begin div_req = 1'b1; div_val = 8'd3; end
        3: div_val = 8'd7;
        5: div_req = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_stop();
    obs_t got, want;
    reset_dut();
    exp_idle(1);
    exp_period(5, 5);
    exp_period(0, 7);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      got  = {div_ack, clk_en, clk_div, running, div_cur};
      want = (sb.size() != 0) ? sb.pop_front() : 'x;
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL stop cyc %0d: got %h want %h", i, got, want);
      end
      case (i)
        0: begin div_req = 1'b1; div_val = 8'd5; end
        1: div_req = 1'b0;
        5: begin div_req = 1'b1; div_val = 8'd0; end
        6: div_req = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_n1_n2();
    obs_t got, want;
    reset_dut();
    exp_idle(1);
    exp_period(1, 4);
    exp_period(2, 8);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      got  = {div_ack, clk_en, clk_div, running, div_cur};
      want = (sb.size() != 0) ? sb.pop_front() : 'x;
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL n1_n2 cyc %0d: got %h want %h", i, got, want);
      end
      case (i)
        0: begin div_req = 1'b1; div_val = 8'd1; end
        1: div_req = 1'b0;
        4: begin div_req = 1'b1; div_val = 8'd2; end
        5: div_req = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, want;
    reset_dut();
    exp_idle(1);
    exp_period(3, 12);
    exp_period(6, 12);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      got  = {div_ack, clk_en, clk_div, running, div_cur};
      want = (sb.size() != 0) ? sb.pop_front() : 'x;
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %h want %h", i, got, want);
      end
      case (i)
        0:  begin div_req = 1'b1; div_val = 8'd3; end
        7:  div_req = 1'b0;
        10: begin div_req = 1'b1; div_val = 8'd6; end
        13: div_req = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset_midway();
    obs_t got, want;
    reset_dut();
    exp_idle(1);
    exp_period(7, 5);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      got  = {div_ack, clk_en, clk_div, running, div_cur};
      want = (sb.size() != 0) ? sb.pop_front() : 'x;
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL midway_pre cyc %0d: got %h want %h", i, got, want);
      end
      case (i)
        0: begin div_req = 1'b1; div_val = 8'd7; end
        1: div_req = 1'b0;
        4: begin div_req = 1'b1; div_val = 8'd2; end
        default: ;
      endcase
    end
    #2 rst_n = 1'b0;
    div_req = 1'b0;
    #1;
    sb.push_back(mk(1'b0, 0, 0));
    got  = {div_ack, clk_en, clk_div, running, div_cur};
    want = sb.pop_front();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL midway_async: got %h want %h", got, want);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_idle(8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got  = {div_ack, clk_en, clk_div, running, div_cur};
      want = (sb.size() != 0) ? sb.pop_front() : 'x;
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL midway_post cyc %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_start();
    test_change_ratio();
    test_stop();
    test_n1_n2();
    test_back_to_back();
    test_reset_midway();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m_clk_div_ctrl.md
Name: m_clk_div_ctrl

Overview:
- Programmable clock-divider controller. Sits next to the clock-tree gate cells and drives their enable and divided-clock inputs: the NAND-based gating cells consume, this block produces.
- Generates a one-cycle clock-enable pulse per divided period and a registered square-wave divided clock.
- The divide ratio changes only through a 4-phase req/ack handshake, and a change takes effect only at a period boundary. Downstream logic therefore never sees a truncated or glitched period.

Parameters:
- DIV_W, 8, width of the divide ratio.
- RESET_DIV, 0, ratio active out of reset (0 = stopped).

Ports:
- clk  in  1  block clock. Reset is asynchronous, active-low, on rst_n.
- rst_n  in  1  asynchronous active-low reset.
- div_req  in  1  ratio change request. Level signal, held until div_ack.
- div_val  in  DIV_W  requested ratio. Must be stable while div_req is high.
- div_ack  out  1  one-cycle pulse: the new ratio is in effect from this cycle.
- clk_en  out  1  one-cycle pulse in the last cycle of each divided period.
- clk_div  out  1  divided clock, registered, glitch-free.
- div_cur  out  DIV_W  ratio currently in effect.
- running  out  1  high when div_cur != 0.

Behaviour:
- Reset (asynchronous, any time, including mid-period or mid-handshake):
  - cnt=0, pending flag cleared, div_ack=0, div_cur=RESET_DIV.
  - If RESET_DIV=0: state=IDLE, clk_en=0, clk_div=0, running=0.
  - If RESET_DIV!=0: state=RUN. The first cycle after rst_n deasserts is cycle 0 of a period, and running=1.
- States:
  - IDLE: stopped.
  - RUN: dividing, no request pending.
  - PEND: dividing, request captured.
  - ACKW: ack sent, waiting for div_req low.
- Period, for ratio N>=1:
  - Internal cnt runs 0..N-1 and wraps to 0.
  - clk_en=1 exactly when cnt==N-1. N=1 gives clk_en high every cycle.
  - clk_div=1 when cnt < floor(N/2). N=1 gives constant 0. Odd N gives a shorter high phase.
  - Outputs derive from registers only, with no combinational path from inputs.
- Ratio change:
  - IDLE, div_req seen in cycle t: latch div_val. Cycle t+1: div_cur=div_val, cnt=0, div_ack=1, then go to ACKW.
  - RUN, div_req seen in cycle t: latch div_val and go to PEND. The period continues unchanged. Let e be the first cycle >= t with clk_en=1. Cycle e+1: div_cur=new, cnt=0, div_ack=1, then go to ACKW. A request first seen in a clk_en cycle gives e=t.
  - New ratio 0: at the boundary go to IDLE. clk_en=0, clk_div=0, running=0 from cycle e+1. div_ack is still pulsed.
  - Same ratio as current: full handshake. The period sequence is unaffected.
  - ACKW keeps dividing at the new ratio. It ignores div_req while it is high and returns to RUN or IDLE once div_req=0. A request re-raised after that point is a new request.
  - div_val changes while div_req is high are ignored, because div_val is latched at capture.
- div_ack is high for exactly one cycle per request, never spontaneously.
- Counter arithmetic is unsigned DIV_W bits. The N-1 compare has no overflow for N up to 2^DIV_W-1.

Test Plan:
- Reset with RESET_DIV=0; req with div_val=4 at cycle 10 -> div_ack at cycle 11; clk_en at 14, 18, 22; clk_div high in cycles 11-12 and 15-16; running=1 from cycle 11.
- Running at N=4 (period starts cycle 0); req with div_val=3 at cycle 1 -> old period finishes, clk_en at 3; div_ack and new cycle 0 at 4; clk_en at 6, 9.
- Running at N=5; req with div_val=0 raised in the clk_en cycle -> next cycle div_ack=1, running=0, clk_en and clk_div stay 0.
- N=1 -> clk_en high every cycle, clk_div constant 0. Change to N=2 -> clk_en on alternate cycles, clk_div toggles every cycle.
- Hold div_req high 5 cycles after ack -> exactly one ack. Drop div_req, then re-raise with div_val=6 -> second ack at the next boundary.
- Assert rst_n low mid-period and mid-PEND at N=7 -> outputs return to reset values immediately. No ack after release, ratio=RESET_DIV.
